// File: rtl/wash_pkg.sv
// Shared encodings for the wash panel controller.
// Machine/panel state enums, button indices, default prices.
package wash_pkg;

   localparam int MS_W = 3;

   typedef enum logic [2:0] {
      M_IDLE     = 3'd0,
      M_FILLING  = 3'd1,
      M_WASHING  = 3'd2,
      M_RINSING  = 3'd3,
      M_SPINNING = 3'd4
   } m_state_e;

   typedef enum logic [1:0] {
      P_IDLE,
      P_REQUEST,
      P_RUNNING,
      P_DONE
   } p_state_e;

   localparam int WASH_PRICE_D   = 2;
   localparam int DOUBLE_PRICE_D = 3;

   localparam int B_COIN   = 4;
   localparam int B_START  = 3;
   localparam int B_DBL    = 2;
   localparam int B_PAUSE  = 1;
   localparam int B_CANCEL = 0;

endpackage

// File: rtl/wash_panel_ctrl_if.sv
// Panel <-> machine controller link.
// master: panel drives coin/double_wash/pause, reads state/done.
interface wash_panel_ctrl_if;
   import wash_pkg::*;

   logic            coin;
   logic            double_wash;
   logic            pause;
   logic [MS_W-1:0] current_state;
   logic            wash_done;

   modport master (
      output coin, double_wash, pause,
      input  current_state, wash_done
   );

   modport slave (
      input  coin, double_wash, pause,
      output current_state, wash_done
   );

endinterface

// File: rtl/panel_debounce.sv
// Button conditioner: 2-FF sync, stable counter, press pulse.
// Ports: clk, rst_n, i_raw (button), o_press (1-cycle pulse).
module panel_debounce #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_raw,
   output logic o_press
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic          r_s1;
   logic          r_s2;
   logic [CW-1:0] r_cnt;

   // r_cnt counts earlier high cycles and parks at the limit,
   // so a held button fires once until the level drops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1  <= 1'b0;
         r_s2  <= 1'b0;
         r_cnt <= '0;
      end else begin
         r_s1 <= i_raw;
         r_s2 <= r_s1;
         if (!r_s2)
            r_cnt <= '0;
         else if (r_cnt != CW'(DEBOUNCE_CYCLES))
            r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_press = r_s2 &&
                    (r_cnt == CW'(DEBOUNCE_CYCLES - 1));

endmodule

// File: rtl/wash_panel_ctrl.sv
// Washing-machine front panel: buttons, credit, request FSM.
// Ports: clk, reset (async low), *_btn_raw, mif (machine link),
//        credit, refund_pulse/amount, state_leds, busy_led,
//        done_buzzer. All outputs registered.
module wash_panel_ctrl
   import wash_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int WASH_PRICE      = WASH_PRICE_D,
   parameter int DOUBLE_PRICE    = DOUBLE_PRICE_D,
   parameter int CREDIT_W        = 4,
   parameter int REQ_TIMEOUT     = 64,
   parameter int BUZZ_CYCLES     = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                coin_btn_raw,
   input  logic                start_btn_raw,
   input  logic                double_btn_raw,
   input  logic                pause_btn_raw,
   input  logic                cancel_btn_raw,
   wash_panel_ctrl_if.master   mif,
   output logic [CREDIT_W-1:0] credit,
   output logic                refund_pulse,
   output logic [CREDIT_W-1:0] refund_amount,
   output logic [4:0]          state_leds,
   output logic                busy_led,
   output logic                done_buzzer
);

   localparam int TMAX  = (REQ_TIMEOUT > BUZZ_CYCLES) ?
                          REQ_TIMEOUT : BUZZ_CYCLES;
   localparam int TMR_W = $clog2(TMAX) + 1;
   localparam int BW    = CREDIT_W + 2;
   localparam logic [CREDIT_W-1:0] C_MAX = '1;

   logic [4:0] w_raw;
   logic [4:0] w_press;

   assign w_raw = {coin_btn_raw, start_btn_raw,
                   double_btn_raw, pause_btn_raw,
                   cancel_btn_raw};

   for (genvar g = 0; g < 5; g++) begin : g_db
      panel_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_db (
         .clk    (clk),
         .rst_n  (reset),
         .i_raw  (w_raw[g]),
         .o_press(w_press[g])
      );
   end

   p_state_e            r_pst, w_npst;
   logic [CREDIT_W-1:0] r_credit, w_ncredit;
   logic                r_ref, w_nref;
   logic [CREDIT_W-1:0] r_ramt, w_nramt;
   logic                r_coin, w_ncoin;
   logic                r_dbl, w_ndbl;
   logic                r_pause, w_npause;
   logic                r_buzz, w_nbuzz;
   logic                r_busy, w_nbusy;
   logic [4:0]          r_leds, w_leds;
   logic [TMR_W-1:0]    r_tmr, w_ntmr;

   logic [CREDIT_W-1:0] w_price;
   logic                w_coin_full;
   logic [CREDIT_W-1:0] w_cred;
   logic [BW-1:0]       w_back;

   always_comb begin
      w_price     = r_dbl ? CREDIT_W'(DOUBLE_PRICE)
                          : CREDIT_W'(WASH_PRICE);
      w_coin_full = w_press[B_COIN] && (r_credit == C_MAX);
      // credit with this cycle's coin already applied
      w_cred      = r_credit +
                    CREDIT_W'(w_press[B_COIN] && !w_coin_full);
      // price handed back on timeout, before saturation
      w_back      = BW'(r_credit) + BW'(w_press[B_COIN]) +
                    BW'(w_price);

      w_npst    = r_pst;
      w_ncredit = w_cred;
      w_nref    = w_coin_full;
      w_nramt   = w_coin_full ? CREDIT_W'(1) : '0;
      w_ncoin   = r_coin;
      w_ndbl    = r_dbl;
      w_npause  = r_pause;
      w_nbuzz   = r_buzz;
      w_ntmr    = r_tmr + 1'b1;

      unique case (r_pst)
         P_IDLE: begin
            w_ntmr = '0;
            if (w_press[B_CANCEL]) begin
               if (w_cred != '0) begin
                  w_nref    = 1'b1;
                  w_nramt   = w_cred;
                  w_ncredit = '0;
               end
            end else if (w_press[B_START] &&
                         (w_cred >= w_price)) begin
               w_ncredit = w_cred - w_price;
               w_ncoin   = 1'b1;
               w_npst    = P_REQUEST;
            end else if (w_press[B_DBL]) begin
               w_ndbl = !r_dbl;
            end
         end
         P_REQUEST: begin
            if (mif.current_state != M_IDLE) begin
               w_ncoin = 1'b0;
               w_ntmr  = '0;
               w_npst  = P_RUNNING;
            end else if (r_tmr == TMR_W'(REQ_TIMEOUT - 1)) begin
               w_ncoin = 1'b0;
               w_ntmr  = '0;
               w_npst  = P_IDLE;
               if (w_back > BW'(C_MAX)) begin
                  w_ncredit = C_MAX;
                  w_nref    = 1'b1;
                  w_nramt   = CREDIT_W'(w_back - BW'(C_MAX));
               end else begin
                  w_ncredit = CREDIT_W'(w_back);
                  w_nref    = 1'b0;
                  w_nramt   = '0;
               end
            end
         end
         P_RUNNING: begin
            w_ntmr = '0;
            if (mif.current_state != M_SPINNING)
               w_npause = 1'b0;
            else if (w_press[B_PAUSE])
               w_npause = !r_pause;
            if (mif.wash_done ||
                (mif.current_state == M_IDLE)) begin
               w_npause = 1'b0;
               w_ndbl   = 1'b0;
               w_nbuzz  = 1'b1;
               w_npst   = P_DONE;
            end
         end
         P_DONE: begin
            if (r_tmr == TMR_W'(BUZZ_CYCLES - 1)) begin
               w_nbuzz = 1'b0;
               w_ntmr  = '0;
               w_npst  = P_IDLE;
            end
         end
         default: begin
            w_npst = P_IDLE;
         end
      endcase

      w_nbusy = (w_npst == P_REQUEST) ||
                (w_npst == P_RUNNING);

      w_leds = '0;
      for (int i = 0; i < 5; i++)
         w_leds[i] = (mif.current_state == MS_W'(i));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pst    <= P_IDLE;
         r_credit <= '0;
         r_ref    <= 1'b0;
         r_ramt   <= '0;
         r_coin   <= 1'b0;
         r_dbl    <= 1'b0;
         r_pause  <= 1'b0;
         r_buzz   <= 1'b0;
         r_busy   <= 1'b0;
         r_leds   <= '0;
         r_tmr    <= '0;
      end else begin
         r_pst    <= w_npst;
         r_credit <= w_ncredit;
         r_ref    <= w_nref;
         r_ramt   <= w_nramt;
         r_coin   <= w_ncoin;
         r_dbl    <= w_ndbl;
         r_pause  <= w_npause;
         r_buzz   <= w_nbuzz;
         r_busy   <= w_nbusy;
         r_leds   <= w_leds;
         r_tmr    <= w_ntmr;
      end
   end

   assign mif.coin        = r_coin;
   assign mif.double_wash = r_dbl;
   assign mif.pause       = r_pause;
   assign credit          = r_credit;
   assign refund_pulse    = r_ref;
   assign refund_amount   = r_ramt;
   assign state_leds      = r_leds;
   assign busy_led        = r_busy;
   assign done_buzzer     = r_buzz;

endmodule

// File: tb/tb_wash_panel_ctrl.sv
// Self-checking bench for wash_panel_ctrl.
// Vector table with scoreboard queue plus multi-cycle sequences.
module tb_wash_panel_ctrl;

   logic       clk;
   logic       reset;
   logic       coin_raw, start_raw, dbl_raw, pause_raw, cancel_raw;
   logic [3:0] credit;
   logic       refund_pulse;
   logic [3:0] refund_amount;
   logic [4:0] state_leds;
   logic       busy_led;
   logic       done_buzzer;

   wash_panel_ctrl_if mif ();

   wash_panel_ctrl dut (
      .clk           (clk),
      .reset         (reset),
      .coin_btn_raw  (coin_raw),
      .start_btn_raw (start_raw),
      .double_btn_raw(dbl_raw),
      .pause_btn_raw (pause_raw),
      .cancel_btn_raw(cancel_raw),
      .mif           (mif),
      .credit        (credit),
      .refund_pulse  (refund_pulse),
      .refund_amount (refund_amount),
      .state_leds    (state_leds),
      .busy_led      (busy_led),
      .done_buzzer   (done_buzzer)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_chk = 0;
   int n_err = 0;
   int n_ref = 0;
   int s_ref = 0;
   int n_coin = 0;
   int n_buzz = 0;

   // event counters sampled away from the active edge
   always @(posedge clk) begin
      #2;
      if (refund_pulse) begin
         n_ref++;
         s_ref += int'(refund_amount);
      end
      if (mif.coin) n_coin++;
      if (done_buzzer) n_buzz++;
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
      end
   endtask

   // mask bits: coin start double pause cancel
   task automatic press(input logic [4:0] m);
      @(negedge clk);
      {coin_raw, start_raw, dbl_raw, pause_raw, cancel_raw} = m;
      repeat (20) @(negedge clk);
      {coin_raw, start_raw, dbl_raw, pause_raw, cancel_raw} = '0;
      repeat (4) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      {coin_raw, start_raw, dbl_raw, pause_raw, cancel_raw} = '0;
      mif.current_state = 3'd0;
      mif.wash_done = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic set_state(input logic [2:0] s, input int wait_n);
      @(negedge clk);
      mif.current_state = s;
      repeat (wait_n) @(negedge clk);
   endtask

   task automatic finish_wash();
      @(negedge clk);
      mif.current_state = 3'd0;
      mif.wash_done = 1'b1;
      @(negedge clk);
      mif.wash_done = 1'b0;
   endtask

   typedef struct {
      logic [4:0] btn;
      int cr;
      int nref;
      int sref;
      int dbl;
      int busy;
   } vec_t;

   localparam int NV = 13;
   vec_t vec [NV];
   vec_t sb [$];

   initial begin
      #1000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int b_ref, b_sum, b_coin, b_buzz, first;
      vec_t e;

      vec[0]  = '{5'b00001, 0, 0, 0, 0, 0};
      vec[1]  = '{5'b10000, 1, 0, 0, 0, 0};
      vec[2]  = '{5'b10000, 2, 0, 0, 0, 0};
      vec[3]  = '{5'b00100, 2, 0, 0, 1, 0};
      vec[4]  = '{5'b01000, 2, 0, 0, 1, 0};
      vec[5]  = '{5'b00100, 2, 0, 0, 0, 0};
      vec[6]  = '{5'b10000, 3, 0, 0, 0, 0};
      vec[7]  = '{5'b00001, 0, 1, 3, 0, 0};
      vec[8]  = '{5'b10001, 0, 1, 1, 0, 0};
      vec[9]  = '{5'b10000, 1, 0, 0, 0, 0};
      vec[10] = '{5'b10100, 2, 0, 0, 1, 0};
      vec[11] = '{5'b00001, 0, 1, 2, 1, 0};
      vec[12] = '{5'b00100, 0, 0, 0, 0, 0};

      reset = 1'b1;
      {coin_raw, start_raw, dbl_raw, pause_raw, cancel_raw} = '0;
      mif.current_state = 3'd0;
      mif.wash_done = 1'b0;
      #3 reset = 1'b0;
      #4;
      chk("rst_credit", int'(credit), 0);
      chk("rst_coin", int'(mif.coin), 0);
      chk("rst_busy", int'(busy_led), 0);
      chk("rst_leds", int'(state_leds), 0);
      chk("rst_buzz", int'(done_buzzer), 0);
      chk("rst_refund", int'(refund_pulse), 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_leds", int'(state_leds), 1);

      // bounce then a stable press
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         coin_raw = ((i / 3) % 2 == 0);
      end
      @(negedge clk);
      coin_raw = 1'b0;
      @(negedge clk);
      chk("bounce_nocredit", int'(credit), 0);
      coin_raw = 1'b1;
      first = 0;
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk);
         if (first == 0 && credit != 0) first = i;
      end
      chk("bounce_latency", first, 18);
      chk("bounce_credit", int'(credit), 1);
      coin_raw = 1'b0;

      // idle-state vector table
      do_reset();
      for (int i = 0; i < NV; i++) begin
         b_ref = n_ref;
         b_sum = s_ref;
         sb.push_back(vec[i]);
         press(vec[i].btn);
         e = sb.pop_front();
         chk($sformatf("v%0d_credit", i), int'(credit), e.cr);
         chk($sformatf("v%0d_nref", i), n_ref - b_ref, e.nref);
         chk($sformatf("v%0d_sref", i), s_ref - b_sum, e.sref);
         chk($sformatf("v%0d_dbl", i), int'(mif.double_wash), e.dbl);
         chk($sformatf("v%0d_busy", i), int'(busy_led), e.busy);
      end

      // single wash
      do_reset();
      press(5'b10000);
      press(5'b10000);
      press(5'b01000);
      chk("sw_credit", int'(credit), 0);
      chk("sw_coin_req", int'(mif.coin), 1);
      chk("sw_busy_req", int'(busy_led), 1);
      set_state(3'd1, 1);
      chk("sw_coin_run", int'(mif.coin), 0);
      chk("sw_busy_run", int'(busy_led), 1);
      chk("sw_leds1", int'(state_leds), 2);
      set_state(3'd4, 1);
      chk("sw_leds4", int'(state_leds), 16);
      set_state(3'd5, 1);
      chk("sw_leds5", int'(state_leds), 0);
      chk("sw_busy5", int'(busy_led), 1);
      b_buzz = n_buzz;
      finish_wash();
      chk("sw_buzz_on", int'(done_buzzer), 1);
      repeat (15) @(negedge clk);
      chk("sw_buzz_len", n_buzz - b_buzz, 8);
      chk("sw_busy_end", int'(busy_led), 0);

      // double wash with change
      do_reset();
      press(5'b00100);
      for (int i = 0; i < 5; i++) press(5'b10000);
      chk("dw_credit5", int'(credit), 5);
      press(5'b01000);
      chk("dw_dbl", int'(mif.double_wash), 1);
      chk("dw_credit", int'(credit), 2);
      set_state(3'd2, 2);
      b_ref = n_ref;
      press(5'b00001);
      chk("dw_cancel_run", n_ref - b_ref, 0);
      chk("dw_credit_run", int'(credit), 2);
      finish_wash();
      repeat (12) @(negedge clk);
      chk("dw_dbl_clr", int'(mif.double_wash), 0);
      b_ref = n_ref;
      b_sum = s_ref;
      press(5'b00001);
      chk("dw_ref_n", n_ref - b_ref, 1);
      chk("dw_ref_amt", s_ref - b_sum, 2);
      chk("dw_credit_end", int'(credit), 0);

      // pause gating
      do_reset();
      press(5'b10000);
      press(5'b10000);
      press(5'b01000);
      set_state(3'd2, 2);
      press(5'b00010);
      chk("pa_wash", int'(mif.pause), 0);
      set_state(3'd4, 1);
      press(5'b00010);
      chk("pa_on", int'(mif.pause), 1);
      press(5'b00010);
      chk("pa_off", int'(mif.pause), 0);
      press(5'b00010);
      chk("pa_on2", int'(mif.pause), 1);
      set_state(3'd3, 1);
      chk("pa_force3", int'(mif.pause), 0);
      set_state(3'd4, 1);
      chk("pa_stay0", int'(mif.pause), 0);
      press(5'b00010);
      chk("pa_on3", int'(mif.pause), 1);
      set_state(3'd0, 1);
      chk("pa_force0", int'(mif.pause), 0);
      repeat (12) @(negedge clk);

      // request timeout
      do_reset();
      press(5'b10000);
      press(5'b10000);
      b_coin = n_coin;
      b_ref = n_ref;
      press(5'b01000);
      chk("to_coin_hi", int'(mif.coin), 1);
      repeat (60) @(negedge clk);
      chk("to_coin_lo", int'(mif.coin), 0);
      chk("to_coin_len", n_coin - b_coin, 64);
      chk("to_credit", int'(credit), 2);
      chk("to_busy", int'(busy_led), 0);
      chk("to_noref", n_ref - b_ref, 0);

      // saturation then reset mid-wash
      do_reset();
      b_ref = n_ref;
      b_sum = s_ref;
      for (int i = 0; i < 16; i++) press(5'b10000);
      chk("sat_credit", int'(credit), 15);
      chk("sat_ref_n", n_ref - b_ref, 1);
      chk("sat_ref_amt", s_ref - b_sum, 1);
      press(5'b01000);
      chk("sat_credit13", int'(credit), 13);
      set_state(3'd2, 2);
      chk("sat_busy", int'(busy_led), 1);
      b_ref = n_ref;
      @(negedge clk);
      #3 reset = 1'b0;
      #1;
      chk("mr_credit", int'(credit), 0);
      chk("mr_busy", int'(busy_led), 0);
      chk("mr_leds", int'(state_leds), 0);
      chk("mr_coin", int'(mif.coin), 0);
      chk("mr_ref", int'(refund_pulse), 0);
      repeat (3) @(negedge clk);
      chk("mr_noref", n_ref - b_ref, 0);
      reset = 1'b1;
      mif.current_state = 3'd0;
      repeat (2) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/wash_panel_ctrl.md
Name: wash_panel_ctrl

Overview:
Front-panel controller on the user side of the washing-machine controller's coin/double_wash/pause interface.
- Debounces the raw panel buttons and keeps a coin credit balance.
- Drives coin, double_wash and pause into the machine controller.
- Consumes its current_state and wash_done to sequence the panel, light the status LEDs and sound the completion buzzer.
- Sits between the board buttons and the machine controller, in the same clock domain.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive stable synchronized-high cycles before a press is accepted
WASH_PRICE, 2, coins charged for a single wash
DOUBLE_PRICE, 3, coins charged when double wash is selected
CREDIT_W, 4, credit/refund width; credit saturates at 2^CREDIT_W-1
REQ_TIMEOUT, 64, cycles to wait for the machine to leave IDLE after a request
BUZZ_CYCLES, 8, done_buzzer high time

Ports:
clk  input  1  panel clock, same as machine controller clock
reset  input  1  asynchronous, active-low reset
coin_btn_raw  input  1  raw coin-slot switch
start_btn_raw  input  1  raw start button
double_btn_raw  input  1  raw double-wash select button
pause_btn_raw  input  1  raw pause button
cancel_btn_raw  input  1  raw cancel/refund button
current_state  input  3  machine state: 0 IDLE, 1 FILLING, 2 WASHING, 3 RINSING, 4 SPINNING
wash_done  input  1  machine completion flag
coin  output  1  wash request to machine, level
double_wash  output  1  double-wash selection to machine
pause  output  1  spin pause to machine
credit  output  CREDIT_W  current coin balance
refund_pulse  output  1  one-cycle refund strobe
refund_amount  output  CREDIT_W  coins returned; valid only with refund_pulse
state_leds  output  5  one-hot of current_state; bit i set when current_state==i, all zero for values 5-7
busy_led  output  1  high in P_REQUEST and P_RUNNING
done_buzzer  output  1  completion buzzer

Behaviour:
- Reset, asynchronous active-low. All outputs, credit, FSM (P_IDLE), debouncers and timers clear to 0 immediately. This includes reset mid-wash: no refund is issued.
- Button path:
  - Each raw input passes through a 2-FF synchronizer, then a stable counter.
  - A one-cycle press pulse fires when the synchronized level has been high for DEBOUNCE_CYCLES consecutive cycles.
  - Latency from raw rising edge is DEBOUNCE_CYCLES+2 cycles.
  - No further pulse until the level has been low for at least one synchronized cycle.
- Price = DOUBLE_PRICE if double_wash=1, else WASH_PRICE.
- Coin pulse, any panel state: credit+1.
  - If credit is already at max, the coin is returned instead: refund_pulse=1, refund_amount=1, credit unchanged.
- FSM states and transitions:
  - P_IDLE:
    - double press toggles double_wash.
    - start press with credit>=price: credit-=price; go to P_REQUEST next cycle with coin=1.
    - start press with credit<price: ignored.
    - cancel press with credit>0: refund_pulse=1, refund_amount=credit (including a coin arriving the same cycle); credit cleared; cancel wins over coin.
    - cancel press with credit=0: no effect.
  - P_REQUEST:
    - coin held high until current_state!=0 is sampled; then coin=0 and go to P_RUNNING.
    - If REQ_TIMEOUT cycles elapse first: coin=0, credit+=price (saturating; any excess is issued via refund_pulse), return to P_IDLE.
  - P_RUNNING:
    - double and start presses are ignored.
    - cancel is ignored; no mid-wash refund.
    - pause press toggles pause only while current_state==4.
    - pause is forced to 0 on any cycle current_state!=4.
    - wash_done=1 goes to P_DONE.
    - current_state returning to 0 without wash_done also goes to P_DONE.
  - P_DONE:
    - done_buzzer high for exactly BUZZ_CYCLES cycles, then P_IDLE.
    - pause and double_wash are cleared on entry.
- Simultaneous events:
  - coin with start: the coin is credited before the price check.
  - coin with cancel: handled as stated under P_IDLE.
- All outputs are registered. state_leds lags current_state by one cycle.

Decomposition:
- Shared package wash_pkg holds:
  - machine state encodings (IDLE..SPINNING, 3 bits);
  - panel FSM encodings P_IDLE, P_REQUEST, P_RUNNING, P_DONE;
  - default price constants.
- One sub-module, panel_debounce, parameterized by DEBOUNCE_CYCLES, containing the synchronizer, stable counter and rising-edge pulse. It is instantiated five times.

Test Plan:
- Bounce test: toggle coin_btn_raw every 3 cycles for 40 cycles, then hold high 30 cycles -> exactly one credit increment, arriving 18 cycles after the stable high.
- Single wash: 2 coins, then start -> credit 0; coin=1 until current_state=1; busy_led=1; wash_done pulse -> done_buzzer high 8 cycles; back to P_IDLE.
- Double wash with change: double press, then 5 coins, then start -> double_wash=1, credit=2; cancel during run ignored; cancel after done -> refund_pulse with refund_amount=2, credit=0.
- Pause gating: pause press while current_state=2 -> pause stays 0; press at state 4 -> pause=1; second press -> 0; state forced 4->0 -> pause=0.
- Request timeout: 2 coins, start, machine held at state 0 for 64 cycles -> coin drops, credit back to 2.
- Saturation and reset: 16 coins -> credit 15 plus one refund of amount 1; reset asserted in P_RUNNING -> all outputs 0 immediately, no refund.
